srt4_div_arbiter: RTL

//  Shares one SRT4 divider instance (11b/11b -> 10b sign+9b quotient, 3-cycle latency) between
//  NUM_REQ disparity-refinement lanes. Round-robin grant, operand hold sequencing, divide-by-zero

---
 rtl/srt4_div_arbiter.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/srt4_div_arbiter.sv
// Shares one 3-cycle SRT4 divider between NUM_REQ lanes: round-robin grant, two-cycle operand
// hold, divide-by-zero bypass through the tag pipe, and one in-order backpressured response port.
module srt4_div_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int DIV_LAT = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*11-1:0] req_x,
    input  logic [NUM_REQ*11-1:0] req_d,
    input  logic [NUM_REQ-1:0]    req_f,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ID_W-1:0]       rsp_id,
    output logic [9:0]            rsp_q,
    output logic                  rsp_dz,
    output logic                  div_clken,
    output logic                  div_validin,
    output logic [10:0]           div_x,
    output logic [10:0]           div_d,
    output logic                  div_f,
    input  logic [9:0]            div_q,
    input  logic                  div_valid,
    output logic                  err
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_HOLD
    } state_t;

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
        logic            dz;
        logic            f;
    } tag_t;

    state_t          state;
    state_t          state_nx;
    logic            live;
    logic            stall;
    logic            run;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] gnt_idx;
    logic            gnt_found;
    logic            take;
    logic [ID_W-1:0] op_id;
    logic            op_dz;
    logic [10:0]     lane_x [NUM_REQ];
    logic [10:0]     lane_d [NUM_REQ];
    tag_t            tag_pipe [DIV_LAT];
    tag_t            exit_tag;
    logic            exit_div;
    logic            load;

    // live keeps every output low while reset is held and for the first edge after release.
    assign stall     = rsp_valid & ~rsp_ready;
    assign run       = live & ~stall;
    assign div_clken = run;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) live <= 1'b0;
        else      live <= 1'b1;
    end

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            lane_x[i] = req_x[i*11 +: 11];
            lane_d[i] = req_d[i*11 +: 11];
        end
    end

    // First valid lane at or after rr_ptr, wrapping.
    always_comb begin
        int              idx;
        logic [ID_W-1:0] cand;
        // NOTE: every combinational output gets a default first so no path infers a latch.
        gnt_found = 1'b0;
        gnt_idx   = '0;
        idx       = 0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            cand = ID_W'(idx);
            if (!gnt_found && req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    // HOLD doubles as a grant slot, so back-to-back requests issue every 2 enabled cycles.
    always_comb begin
        state_nx    = state;
        take        = 1'b0;
        div_validin = 1'b0;
        case (state)
            ST_IDLE: begin
                take = run & gnt_found;
                if (take) state_nx = ST_ISSUE;
            end
            ST_ISSUE: begin
                div_validin = ~op_dz;
                if (run) state_nx = ST_HOLD;
            end
            ST_HOLD: begin
                take = run & gnt_found;
                if (take)     state_nx = ST_ISSUE;
                else if (run) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = take && (gnt_idx == ID_W'(i));
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr <= '0;
            div_x  <= '0;
            div_d  <= '0;
            div_f  <= 1'b0;
            op_id  <= '0;
        end else if (take) begin
            rr_ptr <= (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
            div_x  <= lane_x[gnt_idx];
            div_d  <= lane_d[gnt_idx];
            div_f  <= req_f[gnt_idx];
            op_id  <= gnt_idx;
        end
    end

    assign op_dz = (div_d == '0);

    // NOTE: the tag pipe is reset, unlike a datapath memory, so stale tags can never emit a response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DIV_LAT; i++) tag_pipe[i] <= '0;
        end else if (run) begin
            if (state == ST_ISSUE) tag_pipe[0] <= '{valid: 1'b1, id: op_id, dz: op_dz, f: div_f};
            else                   tag_pipe[0] <= '0;
            for (int i = 1; i < DIV_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
        end
    end

    assign exit_tag = tag_pipe[DIV_LAT-1];
    assign exit_div = exit_tag.valid & ~exit_tag.dz;
    assign load     = run & exit_tag.valid;

    // A dz tag takes the saturated result in its own slot, keeping responses in issue order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_q     <= '0;
            rsp_dz    <= 1'b0;
        end else if (load) begin
            rsp_valid <= 1'b1;
            rsp_id    <= exit_tag.id;
            rsp_q     <= exit_tag.dz ? {exit_tag.f, 9'h1FF} : div_q;
            rsp_dz    <= exit_tag.dz;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                       err <= 1'b0;
        else if (div_valid != exit_div) err <= 1'b1;
    end

endmodule
